// File: rtl/cpu_pkg.sv
// cpu_pkg: step opcodes and default register map shared by the register file
package cpu_pkg;
   typedef enum logic [1:0] {
      STEP_NONE = 2'b00,
      STEP_INC  = 2'b01,
      STEP_DEC  = 2'b10,
      STEP_RSV  = 2'b11
   } step_op_t;
   localparam int REG_A = 0;
   localparam int REG_X = 1;
   localparam int REG_Y = 2;
   localparam int REG_S = 3;
endpackage

// File: rtl/reg_step.sv
// reg_step: combinational WIDTH-bit increment/decrement with wrap detect
module reg_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] din,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] dout,
   output logic             wrap
);
   assign dout = inc ? din + 1'b1 : dec ? din - 1'b1 : din;
   assign wrap = (inc && &din) || (dec && !(|din));
endmodule

// File: rtl/reg_file.sv
// reg_file: small register file with one load port, one inc/dec port, two reads and status flags
module reg_file
   import cpu_pkg::*;
#(
   parameter int              WIDTH   = 8,
   parameter int              NREGS   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter int              BYPASS  = 0,
   localparam int             SW      = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_en,
   input  logic [SW-1:0]    ld_sel,
   input  logic [WIDTH-1:0] ld_data,
   input  logic [1:0]       step_op,
   input  logic [SW-1:0]    step_sel,
   input  logic [SW-1:0]    rd_sel_a,
   input  logic [SW-1:0]    rd_sel_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_vld,
   output logic             wrap
);
   logic [WIDTH-1:0] regs [NREGS];
   logic             ld_ok, inc, dec, st_ok, st_wrap;
   logic [WIDTH-1:0] st_res, wr_val;
   assign inc    = step_op == STEP_INC;
   assign dec    = step_op == STEP_DEC;
   assign ld_ok  = ld_en && 32'(ld_sel) < NREGS;
   // a load to the same register wins; the step is dropped entirely
   assign st_ok  = (inc || dec) && 32'(step_sel) < NREGS && !(ld_ok && ld_sel == step_sel);
   assign wr_val = ld_ok ? ld_data : st_res;
   reg_step #(.WIDTH(WIDTH)) u_step (
      .din  (regs[step_sel]),
      .inc  (inc),
      .dec  (dec),
      .dout (st_res),
      .wrap (st_wrap)
   );
   assign rd_data_a = (BYPASS != 0 && ld_ok && ld_sel == rd_sel_a) ? ld_data :
                      32'(rd_sel_a) < NREGS ? regs[rd_sel_a] : '0;
   assign rd_data_b = (BYPASS != 0 && ld_ok && ld_sel == rd_sel_b) ? ld_data :
                      32'(rd_sel_b) < NREGS ? regs[rd_sel_b] : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= RST_VAL;
         flag_z   <= RST_VAL == '0;
         flag_n   <= RST_VAL[WIDTH-1];
         flag_vld <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         if (ld_ok) regs[ld_sel] <= ld_data;
         if (st_ok) regs[step_sel] <= st_res;
         if (ld_ok || st_ok) begin
            flag_z <= wr_val == '0;
            flag_n <= wr_val[WIDTH-1];
         end
         flag_vld <= ld_ok || st_ok;
         wrap     <= st_ok && st_wrap;
      end
   end
endmodule
